// File: rtl/cpu_sram_ctrl.sv
// cpu_sram_ctrl
//   Memory-side stage behind the V20 bus front-end. It keeps an external
//   asynchronous 8-bit SRAM reading the current CPU address while idle, so a
//   read strobe returns data one cycle after it is sampled. A write strobe
//   starts a timed sequence: bus turnaround, data setup, WE pulse, data hold
//   and release. Any strobe arriving during that sequence is dropped and
//   flagged in a sticky overrun bit.
//
// Optional feature (macro CPU_SRAM_ROM_PROTECT_EN):
//   When defined, writes to addresses >= ROM_BASE are silently discarded.
//   When undefined, every write proceeds and ROM_BASE is unused.
//
// Ports:
//   iClk, iRstN            clock, asynchronous active-low reset
//   iCpuAddr[19:0]         CPU address (stable >= 1 cycle before a strobe)
//   iCpuData[7:0]          CPU write data, valid with iCpuMemWr
//   iCpuMemRd, iCpuMemWr   single-cycle read / write strobes
//   oCpuData[7:0]          read data to CPU, held between reads
//   oBusy                  write sequence in progress
//   oOverrun               sticky: strobe arrived while busy
//   oSramAddr[ADDR_W-1:0]  SRAM address
//   oSramData[7:0]         SRAM write data
//   oSramDataOe            1 = FPGA drives the SRAM data bus
//   iSramData[7:0]         SRAM read data
//   oSramCeN/OeN/WeN       SRAM chip / output / write enables, active low
module cpu_sram_ctrl #(
  parameter int          ADDR_W   = 19,
  parameter int          WR_SETUP = 1,
  parameter int          WR_PULSE = 2,
  parameter int          WR_HOLD  = 1,
  parameter logic [19:0] ROM_BASE = 20'hF0000
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic [19:0]       iCpuAddr,
  input  logic [7:0]        iCpuData,
  input  logic              iCpuMemRd,
  input  logic              iCpuMemWr,
  output logic [7:0]        oCpuData,
  output logic              oBusy,
  output logic              oOverrun,
  output logic [ADDR_W-1:0] oSramAddr,
  output logic [7:0]        oSramData,
  output logic              oSramDataOe,
  input  logic [7:0]        iSramData,
  output logic              oSramCeN,
  output logic              oSramOeN,
  output logic              oSramWeN
);

  localparam int CNT_MAX = (WR_SETUP > WR_PULSE)
                           ? ((WR_SETUP > WR_HOLD) ? WR_SETUP : WR_HOLD)
                           : ((WR_PULSE > WR_HOLD) ? WR_PULSE : WR_HOLD);
  // The counter only ever holds (phase length - 1).
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE, TURN, SETUP, PULSE, HOLD, RELEASE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             wr_allowed;

`ifdef CPU_SRAM_ROM_PROTECT_EN
  assign wr_allowed = (iCpuAddr < ROM_BASE);
`else
  logic unused_bits;
  assign wr_allowed  = 1'b1;
  assign unused_bits = ^{iCpuAddr, ROM_BASE};
`endif

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state       <= IDLE;
      cnt         <= '0;
      oCpuData    <= '0;
      oBusy       <= 1'b0;
      oOverrun    <= 1'b0;
      oSramAddr   <= '0;
      oSramData   <= '0;
      oSramDataOe <= 1'b0;
      oSramCeN    <= 1'b1;
      oSramOeN    <= 1'b1;
      oSramWeN    <= 1'b1;
    end else begin
      // Strobes outside IDLE are dropped; remember that it happened.
      if (state != IDLE && (iCpuMemRd || iCpuMemWr))
        oOverrun <= 1'b1;

      case (state)
        IDLE: begin
          // Continuous read of the current address so read data is ready
          // one cycle after the strobe.
          oSramAddr   <= iCpuAddr[ADDR_W-1:0];
          oSramCeN    <= 1'b0;
          oSramOeN    <= 1'b0;
          oSramDataOe <= 1'b0;
          oSramWeN    <= 1'b1;
          if (iCpuMemWr && wr_allowed) begin
            oSramData <= iCpuData;
            oSramOeN  <= 1'b1;
            oBusy     <= 1'b1;
            state     <= TURN;
          end else if (iCpuMemRd && !iCpuMemWr) begin
            oCpuData <= iSramData;
          end
        end
        TURN: begin
          // SRAM output drivers are off now; safe to drive the bus.
          oSramDataOe <= 1'b1;
          cnt         <= CNT_W'(WR_SETUP - 1);
          state       <= SETUP;
        end
        SETUP: begin
          if (cnt == '0) begin
            oSramWeN <= 1'b0;
            cnt      <= CNT_W'(WR_PULSE - 1);
            state    <= PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            oSramWeN <= 1'b1;
            cnt      <= CNT_W'(WR_HOLD - 1);
            state    <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            oSramDataOe <= 1'b0;
            state       <= RELEASE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RELEASE: begin
          // Bus released for a full cycle before the SRAM drives it again.
          oSramOeN <= 1'b0;
          oBusy    <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sram_ctrl.sv
// tb_cpu_sram_ctrl
//   Directed bench for cpu_sram_ctrl with a small asynchronous SRAM model
//   (64K entries indexed by the low 16 address bits). Inputs are driven and
//   outputs sampled 1 ns after each rising clock edge.
module tb_cpu_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  cpu_rdata;
  logic        busy;
  logic        overrun;
  logic [18:0] sram_addr;
  logic [7:0]  sram_d;
  logic        sram_doe;
  logic [7:0]  sram_q;
  logic        ce_n;
  logic        oe_n;
  logic        we_n;

  logic [7:0]  mem [0:65535];

  int n_cmp = 0;
  int n_err = 0;

  cpu_sram_ctrl dut (
    .iClk        (clk),
    .iRstN       (rst_n),
    .iCpuAddr    (cpu_addr),
    .iCpuData    (cpu_wdata),
    .iCpuMemRd   (mem_rd),
    .iCpuMemWr   (mem_wr),
    .oCpuData    (cpu_rdata),
    .oBusy       (busy),
    .oOverrun    (overrun),
    .oSramAddr   (sram_addr),
    .oSramData   (sram_d),
    .oSramDataOe (sram_doe),
    .iSramData   (sram_q),
    .oSramCeN    (ce_n),
    .oSramOeN    (oe_n),
    .oSramWeN    (we_n)
  );

  always #5 clk = ~clk;

  // SRAM model: reads combinationally while selected, writes on WE rising.
  always_comb begin
    sram_q = 8'h00;
    if (!ce_n && !oe_n)
      sram_q = mem[sram_addr[15:0]];
  end

  always @(posedge we_n) begin
    if (!ce_n && sram_doe)
      mem[sram_addr[15:0]] = sram_d;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {busy, OeN, DataOe, WeN} for each cycle after a write strobe is sampled.
  logic [3:0] wr_seq [0:6];

  initial begin
    wr_seq[0] = 4'b1101;  // TURN
    wr_seq[1] = 4'b1111;  // SETUP
    wr_seq[2] = 4'b1110;  // PULSE
    wr_seq[3] = 4'b1110;  // PULSE
    wr_seq[4] = 4'b1111;  // HOLD
    wr_seq[5] = 4'b1101;  // RELEASE
    wr_seq[6] = 4'b0001;  // IDLE

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1234] = 8'h5A;

    rst_n = 1'b0; cpu_addr = '0; cpu_wdata = '0; mem_rd = 1'b0; mem_wr = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_ce_n", ce_n, 1);
    check("rst_oe_n", oe_n, 1);
    check("rst_we_n", we_n, 1);
    check("rst_doe", sram_doe, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_wdata", sram_d, 0);

    // Read of a preloaded location
    rst_n = 1'b1;
    cpu_addr = 20'h01234;
    tick();
    check("idle_ce_n", ce_n, 0);
    check("idle_oe_n", oe_n, 0);
    check("idle_we_n", we_n, 1);
    check("idle_addr", sram_addr, 19'h01234);
    mem_rd = 1'b1;
    tick();
    mem_rd = 1'b0;
    check("rd_5a", cpu_rdata, 8'h5A);
    check("rd_we_n", we_n, 1);

    // Write C3 to 00010 and follow the strobe timing cycle by cycle
    cpu_addr = 20'h00010;
    tick();
    mem_wr = 1'b1; cpu_wdata = 8'hC3;
    tick();
    mem_wr = 1'b0; cpu_wdata = 8'h00; cpu_addr = 20'h00099;
    for (int c = 0; c < 7; c++) begin
      check($sformatf("wr_seq_c%0d", c + 1), {busy, oe_n, sram_doe, we_n}, wr_seq[c]);
      if (c < 6) begin
        check($sformatf("wr_addr_c%0d", c + 1), sram_addr, 19'h00010);
        check($sformatf("wr_data_c%0d", c + 1), sram_d, 8'hC3);
      end
      if (c < 6) tick();
    end
    cpu_addr = 20'h00010;
    tick();
    mem_rd = 1'b1;
    tick();
    mem_rd = 1'b0;
    check("rdback_c3", cpu_rdata, 8'hC3);

    // Read and write together: write wins, read data retained
    cpu_addr = 20'h00020;
    tick();
    mem_rd = 1'b1; mem_wr = 1'b1; cpu_wdata = 8'h11;
    tick();
    mem_rd = 1'b0; mem_wr = 1'b0;
    check("rdwr_keep", cpu_rdata, 8'hC3);
    check("rdwr_busy", busy, 1);
    repeat (6) tick();
    check("rdwr_done", busy, 0);
    mem_rd = 1'b1;
    tick();
    mem_rd = 1'b0;
    check("rdwr_rdback", cpu_rdata, 8'h11);
    check("rdwr_no_ovr", overrun, 0);

    // Read strobe during a write sequence
    cpu_addr = 20'h01234;
    tick();
    mem_wr = 1'b1; cpu_wdata = 8'h77;
    tick();
    mem_wr = 1'b0;
    tick();
    mem_rd = 1'b1;
    tick();
    mem_rd = 1'b0;
    check("ovr_set", overrun, 1);
    check("ovr_rdata", cpu_rdata, 8'h11);
    repeat (4) tick();
    check("ovr_idle", busy, 0);
    check("ovr_sticky", overrun, 1);
    mem_rd = 1'b1;
    tick();
    mem_rd = 1'b0;
    check("ovr_rdback", cpu_rdata, 8'h77);
    check("ovr_mem20", mem[16'h0020], 8'h11);
    check("ovr_sticky2", overrun, 1);

    // Asynchronous reset in the middle of the WE pulse
    cpu_addr = 20'h00030;
    tick();
    mem_wr = 1'b1; cpu_wdata = 8'hAA;
    tick();
    mem_wr = 1'b0;
    tick(); tick();
    check("pulse_we_n", we_n, 0);
    check("pulse_doe", sram_doe, 1);
    rst_n = 1'b0;
    #1;
    check("arst_we_n", we_n, 1);
    check("arst_doe", sram_doe, 0);
    check("arst_busy", busy, 0);
    check("arst_ovr", overrun, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("post_busy", busy, 0);
    check("post_ovr", overrun, 0);
    check("post_ce_n", ce_n, 0);
    check("post_oe_n", oe_n, 0);
    check("post_we_n", we_n, 1);

`ifdef CPU_SRAM_ROM_PROTECT_EN
    // Protected write is discarded
    cpu_addr = 20'hF8000;
    tick();
    mem_wr = 1'b1; cpu_wdata = 8'hFF;
    tick();
    mem_wr = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("rom_we_n_c%0d", c + 1), we_n, 1);
      check($sformatf("rom_busy_c%0d", c + 1), busy, 0);
      tick();
    end
    check("rom_ovr", overrun, 0);
    // Just below the protected range: normal write
    cpu_addr = 20'hEFFFF;
    tick();
    mem_wr = 1'b1; cpu_wdata = 8'h5C;
    tick();
    mem_wr = 1'b0;
    check("below_rom_busy", busy, 1);
    repeat (6) tick();
    check("below_rom_idle", busy, 0);
    mem_rd = 1'b1;
    tick();
    mem_rd = 1'b0;
    check("below_rom_rdback", cpu_rdata, 8'h5C);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
